zxuno_regport: RTL

Front-end register-port decoder for the ZX-UNO register bank, sitting between the Z80 I/O bus and every peripheral register (core ID string, scandoubler and keyboard config, and the rest). It turns raw CPU I/O cycles on the address port and the data port into one address latch and a clean strobe set: `zxuno_addr`, `zxuno_regrd`, `zxuno_regwr` and `regaddr_changed`, all in the `clk` domain. Downstream register blocks consume these directly and never look at the CPU bus.

---
 rtl/zxuno_pkg.sv | 13 +
 rtl/zxuno_regport_if.sv | 28 ++
 rtl/io_cycle_detect.sv | 43 ++++
 rtl/zxuno_regport.sv | 94 +++++++++
 4 files changed

// File: rtl/zxuno_pkg.sv
// Shared constants and types for the ZX-UNO register-port front end.
package zxuno_pkg;

   localparam logic [15:0] ZXUNO_ADDR_PORT = 16'hFC3B;
   localparam logic [15:0] ZXUNO_DATA_PORT = 16'hFD3B;

   // Per-detector states: IDLE waits for a decoded cycle, ACTIVE tracks it to its end.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } det_state_e;

endpackage

// File: rtl/zxuno_regport_if.sv
// CPU I/O bus plus register-bank strobes seen by the ZX-UNO register-port decoder.
interface zxuno_regport_if;

   logic [15:0] a;
   logic        iorq_n;
   logic        rd_n;
   logic        wr_n;
   logic        m1_n;
   logic [7:0]  din;
   logic [7:0]  zxuno_addr;
   logic        zxuno_regrd;
   logic        zxuno_regwr;
   logic [7:0]  zxuno_din;
   logic        regaddr_changed;
   logic [7:0]  dout;
   logic        oe_n;

   modport master (
      output a, iorq_n, rd_n, wr_n, m1_n, din,
      input  zxuno_addr, zxuno_regrd, zxuno_regwr, zxuno_din, regaddr_changed, dout, oe_n
   );

   modport slave (
      input  a, iorq_n, rd_n, wr_n, m1_n, din,
      output zxuno_addr, zxuno_regrd, zxuno_regwr, zxuno_din, regaddr_changed, dout, oe_n
   );

endinterface

// File: rtl/io_cycle_detect.sv
// One write-cycle tracker: holds the last data seen while the condition is true and
// emits a one-clock strobe, together with the held value, when the condition drops.
module io_cycle_detect
   import zxuno_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cond,
   input  logic [7:0] data,
   output logic       strobe,
   output logic [7:0] value
);

   det_state_e state;
   logic [7:0] hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         hold   <= 8'h00;
         strobe <= 1'b0;
         value  <= 8'h00;
      end else begin
         strobe <= 1'b0;
         // Capture on the entry cycle too, so a one-clock cycle still has its data.
         if (cond) hold <= data;
         case (state)
            IDLE: begin
               if (cond) state <= ACTIVE;
            end
            ACTIVE: begin
               if (!cond) begin
                  state  <= IDLE;
                  strobe <= 1'b1;
                  value  <= hold;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/zxuno_regport.sv
// ZX-UNO register-port decoder: turns Z80 I/O cycles into register address/strobes.
// Optional readback of the address port is enabled by ZXUNO_ADDR_READBACK_EN.
module zxuno_regport
   import zxuno_pkg::*;
#(
   parameter logic [15:0] ADDR_PORT = ZXUNO_ADDR_PORT,
   parameter logic [15:0] DATA_PORT = ZXUNO_DATA_PORT
) (
   input logic             clk,
   input logic             rst,
   zxuno_regport_if.slave  bus
);

   logic [15:0] a_r;
   logic        iorq_r;
   logic        rd_r;
   logic        wr_r;
   logic        m1_r;
   logic [7:0]  din_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= 16'h0000;
         iorq_r <= 1'b1;
         rd_r   <= 1'b1;
         wr_r   <= 1'b1;
         m1_r   <= 1'b1;
         din_r  <= 8'h00;
      end else begin
         a_r    <= bus.a;
         iorq_r <= bus.iorq_n;
         rd_r   <= bus.rd_n;
         wr_r   <= bus.wr_n;
         m1_r   <= bus.m1_n;
         din_r  <= bus.din;
      end
   end

   // M1 together with IORQ is an interrupt acknowledge and must never decode.
   logic io_ok;
   logic cond_aw;
   logic cond_dw;
   logic cond_dr;

   always_comb begin
      io_ok   = !iorq_r && m1_r;
      cond_aw = io_ok && !wr_r && (a_r == ADDR_PORT);
      cond_dw = io_ok && !wr_r && (a_r == DATA_PORT);
      cond_dr = io_ok && !rd_r && (a_r == DATA_PORT);
   end

   io_cycle_detect u_aw (
      .clk    (clk),
      .rst    (rst),
      .cond   (cond_aw),
      .data   (din_r),
      .strobe (bus.regaddr_changed),
      .value  (bus.zxuno_addr)
   );

   io_cycle_detect u_dw (
      .clk    (clk),
      .rst    (rst),
      .cond   (cond_dw),
      .data   (din_r),
      .strobe (bus.zxuno_regwr),
      .value  (bus.zxuno_din)
   );

   always_ff @(posedge clk) begin
      if (rst) bus.zxuno_regrd <= 1'b0;
      else     bus.zxuno_regrd <= cond_dr;
   end

`ifdef ZXUNO_ADDR_READBACK_EN
   logic cond_ar;

   always_comb cond_ar = io_ok && !rd_r && (a_r == ADDR_PORT);

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.oe_n <= 1'b1;
         bus.dout <= 8'h00;
      end else begin
         bus.oe_n <= !cond_ar;
         bus.dout <= bus.zxuno_addr;
      end
   end
`else
   assign bus.oe_n = 1'b1;
   assign bus.dout = 8'h00;
`endif

endmodule
